// File: rtl/mem_stage_if.sv
// ============================================================================
// mem_stage_if : EX-to-MEM inputs and MEM/WB outputs of the DLX MEM stage.
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_stage_if;
  logic [31:0] Result;
  logic [31:0] mem_data_ex;
  logic [5:0]  opcode_ex;
  logic [4:0]  towrite_ex;
  logic        MemWrite_mem;
  logic        MemtoReg_mem;
  logic        RegWrite_mem;
  logic [31:0] result_mem;
  logic [4:0]  towrite_mem;
  logic        RegWrite_wb;
  logic        misalign;
  logic [31:0] misalign_addr;

  modport master (
    output Result, mem_data_ex, opcode_ex, towrite_ex,
           MemWrite_mem, MemtoReg_mem, RegWrite_mem,
    input  result_mem, towrite_mem, RegWrite_wb, misalign, misalign_addr
  );

  modport slave (
    input  Result, mem_data_ex, opcode_ex, towrite_ex,
           MemWrite_mem, MemtoReg_mem, RegWrite_mem,
    output result_mem, towrite_mem, RegWrite_wb, misalign, misalign_addr
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : DLX MEM stage with big-endian byte/half/word data memory.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int ADDR_W = 10
) (
  input  wire         clk,
  input  wire         rst_n,
  mem_stage_if.slave  bus
);
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        offset;
  logic [31:0]       rd_word;
  logic [31:0]       wr_word;
  logic [31:0]       load_data;
  logic [31:0]       wb_data;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              is_byte;
  logic              is_half;
  logic              access;
  logic              misal;
  logic              mem_we;
  logic              unused_addr_hi;

  assign word_idx       = bus.Result[ADDR_W+1:2];
  assign offset         = bus.Result[1:0];
  assign unused_addr_hi = ^bus.Result[31:ADDR_W+2];
  assign rd_word        = mem[word_idx];

  assign is_byte = (bus.opcode_ex == OP_LB) || (bus.opcode_ex == OP_LBU) ||
                   (bus.opcode_ex == OP_SB);
  assign is_half = (bus.opcode_ex == OP_LH) || (bus.opcode_ex == OP_LHU) ||
                   (bus.opcode_ex == OP_SH);
  assign access  = bus.MemWrite_mem || bus.MemtoReg_mem;
  // Anything not byte/half (including unknown opcodes) is a word access.
  assign misal   = access && ((is_half && offset[0]) ||
                              (!is_half && !is_byte && (offset != 2'b00)));
  assign mem_we  = bus.MemWrite_mem && !misal;

  always_comb begin
    byte_sel = rd_word[31:24];
    case (offset)
      2'd0: byte_sel = rd_word[31:24];
      2'd1: byte_sel = rd_word[23:16];
      2'd2: byte_sel = rd_word[15:8];
      2'd3: byte_sel = rd_word[7:0];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = offset[1] ? rd_word[15:0] : rd_word[31:16];
  end

  always_comb begin
    load_data = rd_word;
    if (!bus.MemWrite_mem) begin
      case (bus.opcode_ex)
        OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
        OP_LBU:  load_data = {24'h0, byte_sel};
        OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
        OP_LHU:  load_data = {16'h0, half_sel};
        OP_LW:   load_data = rd_word;
        default: load_data = rd_word;
      endcase
    end
    wb_data = bus.MemtoReg_mem ? load_data : bus.Result;
  end

  always_comb begin
    wr_word = rd_word;
    case (bus.opcode_ex)
      OP_SB: begin
        case (offset)
          2'd0: wr_word[31:24] = bus.mem_data_ex[7:0];
          2'd1: wr_word[23:16] = bus.mem_data_ex[7:0];
          2'd2: wr_word[15:8]  = bus.mem_data_ex[7:0];
          2'd3: wr_word[7:0]   = bus.mem_data_ex[7:0];
          default: wr_word = rd_word;
        endcase
      end
      OP_SH: begin
        if (offset[1]) wr_word[15:0]  = bus.mem_data_ex[15:0];
        else           wr_word[31:16] = bus.mem_data_ex[15:0];
      end
      default: wr_word = bus.mem_data_ex;
    endcase
  end

  // Memory contents are never reset; writes are simply gated while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[word_idx] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.result_mem    <= 32'h0;
      bus.towrite_mem   <= 5'h0;
      bus.RegWrite_wb   <= 1'b0;
      bus.misalign      <= 1'b0;
      bus.misalign_addr <= 32'h0;
    end else begin
      bus.result_mem  <= wb_data;
      bus.towrite_mem <= bus.towrite_ex;
      bus.RegWrite_wb <= bus.RegWrite_mem && !misal;
      if (misal) begin
        bus.misalign <= 1'b1;
        if (!bus.misalign) bus.misalign_addr <= bus.Result;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : directed self-checking bench for mem_stage.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;
  localparam logic [5:0] OP_ALU = 6'h00;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  mem_stage_if bus ();

  mem_stage #(.ADDR_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic mw, input logic mr, input logic rw, input logic [4:0] rd);
    bus.opcode_ex    = op;
    bus.Result       = addr;
    bus.mem_data_ex  = data;
    bus.MemWrite_mem = mw;
    bus.MemtoReg_mem = mr;
    bus.RegWrite_mem = rw;
    bus.towrite_ex   = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data);
    set_in(op, addr, data, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
  endtask

  task automatic load(input logic [5:0] op, input logic [31:0] addr, input logic [4:0] rd);
    set_in(op, addr, 32'h0, 1'b0, 1'b1, 1'b1, rd);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    set_in(OP_ALU, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", bus.result_mem, 32'h0);
    chk("rst_towrite", {27'h0, bus.towrite_mem}, 32'h0);
    chk("rst_regwrite", {31'h0, bus.RegWrite_wb}, 32'h0);
    chk("rst_misalign", {31'h0, bus.misalign}, 32'h0);
    chk("rst_misalign_addr", bus.misalign_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    store(OP_SW, 32'h40, 32'hDEADBEEF);
    load(OP_LW, 32'h40, 5'd3);
    chk("lw_after_sw", bus.result_mem, 32'hDEADBEEF);
    chk("lw_regwrite", {31'h0, bus.RegWrite_wb}, 32'h1);
    chk("lw_towrite", {27'h0, bus.towrite_mem}, 32'd3);

    store(OP_SB, 32'h41, 32'hAAAAAA7F);
    load(OP_LW, 32'h40, 5'd4);
    chk("sb_word", bus.result_mem, 32'hDE7FBEEF);
    load(OP_LB, 32'h42, 5'd4);
    chk("lb_neg", bus.result_mem, 32'hFFFFFFBE);
    load(OP_LBU, 32'h42, 5'd4);
    chk("lbu", bus.result_mem, 32'h000000BE);
    load(OP_LH, 32'h40, 5'd4);
    chk("lh_neg", bus.result_mem, 32'hFFFFDE7F);
    load(OP_LHU, 32'h42, 5'd4);
    chk("lhu", bus.result_mem, 32'h0000BEEF);
    load(OP_LB, 32'h41, 5'd4);
    chk("lb_pos", bus.result_mem, 32'h0000007F);
    load(OP_LH, 32'h42, 5'd4);
    chk("lh_low_half", bus.result_mem, 32'hFFFFBEEF);

    store(OP_SW, 32'h44, 32'h11223344);
    store(OP_SH, 32'h46, 32'h9999AABB);
    load(OP_LW, 32'h44, 5'd6);
    chk("sh_word", bus.result_mem, 32'h1122AABB);

    set_in(OP_ALU, 32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 5'd5);
    tick();
    chk("pass_result", bus.result_mem, 32'h12345678);
    chk("pass_towrite", {27'h0, bus.towrite_mem}, 32'd5);
    load(OP_LW, 32'h40, 5'd1);
    chk("pass_mem_kept", bus.result_mem, 32'hDE7FBEEF);

    set_in(OP_SW, 32'h42, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 5'd7);
    tick();
    chk("mis_sw_flag", {31'h0, bus.misalign}, 32'h1);
    chk("mis_sw_addr", bus.misalign_addr, 32'h42);
    chk("mis_sw_regwrite", {31'h0, bus.RegWrite_wb}, 32'h0);
    load(OP_LW, 32'h40, 5'd1);
    chk("mis_sw_no_write", bus.result_mem, 32'hDE7FBEEF);
    load(OP_LH, 32'h45, 5'd2);
    chk("mis_lh_regwrite", {31'h0, bus.RegWrite_wb}, 32'h0);
    chk("mis_lh_addr_kept", bus.misalign_addr, 32'h42);
    load(OP_LB, 32'h43, 5'd2);
    chk("lb_odd_regwrite", {31'h0, bus.RegWrite_wb}, 32'h1);
    chk("lb_odd_data", bus.result_mem, 32'hFFFFFFEF);

    set_in(OP_SW, 32'h44, 32'h55667788, 1'b1, 1'b1, 1'b1, 5'd9);
    tick();
    chk("both_wb_prestore", bus.result_mem, 32'h1122AABB);
    chk("both_regwrite", {31'h0, bus.RegWrite_wb}, 32'h1);
    load(OP_LW, 32'h44, 5'd9);
    chk("both_store_done", bus.result_mem, 32'h55667788);

    store(OP_SW, 32'h80, 32'hCAFEF00D);
    load(OP_LW, 32'h80, 5'd8);
    chk("pre_rst_word", bus.result_mem, 32'hCAFEF00D);
    set_in(OP_SW, 32'h80, 32'h0BADBEEF, 1'b1, 1'b0, 1'b1, 5'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_result", bus.result_mem, 32'h0);
    chk("async_rst_towrite", {27'h0, bus.towrite_mem}, 32'h0);
    chk("async_rst_regwrite", {31'h0, bus.RegWrite_wb}, 32'h0);
    chk("async_rst_misalign", {31'h0, bus.misalign}, 32'h0);
    chk("async_rst_mis_addr", bus.misalign_addr, 32'h0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_misalign", {31'h0, bus.misalign}, 32'h0);
    load(OP_LW, 32'h80, 5'd8);
    chk("rst_store_dropped", bus.result_mem, 32'hCAFEF00D);

    store(OP_SW, 32'h1000, 32'hA5A55A5A);
    load(OP_LW, 32'h0000, 5'd10);
    chk("addr_wrap", bus.result_mem, 32'hA5A55A5A);
    chk("wrap_no_misalign", {31'h0, bus.misalign}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Pipeline MEM stage of the DLX core, directly downstream of the EX stage. It takes the registered ALU result, store data and control bits that EX launches, and performs byte/halfword/word loads and stores against an internal big-endian data memory. It registers the write-back value, destination register and RegWrite into the MEM/WB boundary, and flags misaligned accesses. Its registered result also drives the EX-stage forwarding path as `result_mem`.

## Interface
- `ADDR_W`, 10: word-address width; memory holds 2^ADDR_W 32-bit words.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Result` in 32: EX ALU result, used as the byte address for loads/stores or as the pass-through value.
- `mem_data_ex` in 32: store data from EX.
- `opcode_ex` in 6: instruction opcode in this stage; selects access size and sign.
- `towrite_ex` in 5: destination register.
- `MemWrite_mem`, `MemtoReg_mem`, `RegWrite_mem` in 1 each: control bits from EX.
- `result_mem` out 32: registered write-back value; also the EX forwarding source.
- `towrite_mem` out 5: registered destination register.
- `RegWrite_wb` out 1: registered register-file write enable.
- `misalign` out 1: sticky misaligned-access flag.
- `misalign_addr` out 32: address of the first misaligned access.

## Operation
- Decode from `opcode_ex`:
  - lb `0x20`, lh `0x21`, lw `0x23`, lbu `0x24`, lhu `0x25`.
  - sb `0x28`, sh `0x29`, sw `0x2B`.
  - Any other opcode with `MemWrite_mem=1` or `MemtoReg_mem=1` is treated as a word access.
- Word index is `Result[ADDR_W+1:2]`; byte offset is `Result[1:0]`. Upper address bits are ignored, so addresses wrap modulo memory size.
- Byte order is big-endian: offset 0 is bits [31:24], and halfword offset 0 is bits [31:16].
- Stores: a read-modify-write of the selected byte lanes.
  - sb writes `mem_data_ex[7:0]` into the selected lane.
  - sh writes `mem_data_ex[15:0]` into the selected halfword.
  - sw writes the whole word.
  - Unselected lanes are preserved.
- Loads:
  - lb/lh sign-extend the selected lane.
  - lbu/lhu zero-extend it.
  - lw returns the whole word.
- Write-back mux: the load data when `MemtoReg_mem=1`, otherwise `Result`.
- Misalignment is a halfword access with `Result[0]=1`, or a word access with `Result[1:0]!=0`, on a cycle with `MemWrite_mem` or `MemtoReg_mem` set. On a misaligned access:
  - The memory write is suppressed.
  - `RegWrite_wb` is registered as 0.
  - `misalign` is set. If it was previously clear, `misalign_addr` captures `Result`.
  - `misalign` stays set until reset; later misaligned accesses do not overwrite `misalign_addr`.
- When both `MemWrite_mem` and `MemtoReg_mem` are set, the store takes priority. Write-back data is then the pre-store memory word. `RegWrite_wb` still follows `RegWrite_mem`.

## Timing
- Memory read is combinational from `Result`. The memory write commits on the rising `clk` edge.
- Latency is 1 cycle from EX outputs to `result_mem`, `towrite_mem` and `RegWrite_wb`.
- Load-after-store to the same word in consecutive cycles returns the stored data. The write commits at edge N, and the load reads at edge N+1 without any bypass.
- Reset values: `result_mem=0`, `towrite_mem=0`, `RegWrite_wb=0`, `misalign=0`, `misalign_addr=0`.
- Memory contents are not reset; they are undefined until written.
- Memory writes are blocked while `rst_n=0`.
- Reset asserted mid-access: the in-flight store is dropped if `rst_n` is low at the edge. Pipeline registers clear immediately and asynchronously.

## Test plan
- Store and reload a word:
  - sw `0xDEADBEEF` to `0x40`.
  - Next cycle, lw `0x40` gives `result_mem=0xDEADBEEF` one cycle later, with `RegWrite_wb=1`.
- Byte lanes after that word is stored:
  - sb `0x7F` to `0x41` gives memory word `0xDE7FBEEF`.
  - lb `0x42` gives `0xFFFFFFBE`.
  - lbu `0x42` gives `0x000000BE`.
  - lh `0x40` gives `0xFFFFDE7F`.
  - lhu `0x42` gives `0x0000BEEF`.
- ALU pass-through: `MemtoReg_mem=0`, `Result=0x12345678`, `towrite_ex=5` gives `result_mem=0x12345678` and `towrite_mem=5` next cycle; memory is unchanged.
- Misaligned accesses:
  - sw to `0x42` gives no write (word `0x40` is unchanged), `misalign=1`, `misalign_addr=0x42`.
  - A subsequent lh to `0x45` gives `RegWrite_wb=0`, while `misalign_addr` stays `0x42`.
- Reset:
  - Assert `rst_n=0` mid-cycle during a sw to `0x80`: all outputs go to 0 immediately, and the word at `0x80` keeps its prior value.
  - After release, `misalign=0`.
- Address wrap: with `ADDR_W=10`, sw to `0x1000` then lw from `0x0000` returns the stored value.
